// File: rtl/key_event_fifo.sv
// key_event_fifo: turns debounced key presses into short/long events and
// buffers them in a small first-word-fall-through FIFO with a registered head.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_ARM    | after reset, wait for the key to be released; no events
// ST_IDLE   | no key held; a press pushes the short event
// ST_HELD   | key held, counting towards the long-press threshold
// ST_LONG_DONE | long event already emitted; wait for release (no repeat)
module key_event_fifo #(
  parameter int CODE_W          = 4,
  parameter int DEPTH           = 4,
  parameter int LONG_PRESS_TIME = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_pressed,
  input  logic [CODE_W-1:0]        key_code,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [CODE_W:0]          ev_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     ovf_clear
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(LONG_PRESS_TIME);
  localparam int LAST_I = LONG_PRESS_TIME - 1;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];
  localparam logic [AW:0]   FULL     = DEPTH[AW:0];

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_HELD, ST_LONG_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [CODE_W-1:0] code_l, code_nxt;
  logic              push_req;
  logic [CODE_W:0]   push_data;

  logic [CODE_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, head_idx;
  logic [AW:0]       count_nxt;
  logic [CODE_W:0]   head_nxt;
  logic              pop, full, push_ok, drop;

  // Hold counter never passes the threshold value.
  assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

  // Next-state logic and event generation; the long event reuses the code
  // latched at the press edge so code changes while held are ignored.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = code_l;
    push_req  = 1'b0;
    push_data = '0;
    case (state)
      ST_ARM: begin
        if (!key_pressed) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (key_pressed) begin
          push_req  = 1'b1;
          push_data = {1'b0, key_code};
          cnt_nxt   = '0;
          code_nxt  = key_code;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!key_pressed) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            push_req  = 1'b1;
            push_data = {1'b1, code_l};
            state_nxt = ST_LONG_DONE;
          end
        end
      end
      ST_LONG_DONE: begin
        if (!key_pressed) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  assign ev_valid = (fifo_count != '0);
  assign pop      = ev_valid & ev_ready;
  assign full     = (fifo_count == FULL);
  // A pop on the same edge frees the slot the push needs.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign head_idx = pop ? rd_ptr + 1'b1 : rd_ptr;

  // Next occupancy and next head word; the head bypasses the memory when the
  // entry being written this edge becomes the new head.
  always_comb begin
    count_nxt = fifo_count;
    if (push_ok && !pop)      count_nxt = fifo_count + 1'b1;
    else if (!push_ok && pop) count_nxt = fifo_count - 1'b1;

    head_nxt = '0;
    if (count_nxt == '0)                      head_nxt = '0;
    else if (push_ok && head_idx == wr_ptr)   head_nxt = push_data;
    else                                      head_nxt = mem[head_idx];
  end

  // FIFO storage; contents are discarded on reset through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // FSM, hold counter, pointers, registered head and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ARM;
      cnt        <= '0;
      code_l     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ev_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      code_l     <= code_nxt;
      fifo_count <= count_nxt;
      ev_data    <= head_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: directed scenarios plus a random phase, all
// checked against an event-level reference model (queue of events).
module tb_key_event_fifo;

  localparam int CODE_W = 4;
  localparam int DEPTH  = 4;
  localparam int LPT    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_pressed;
  logic [CODE_W-1:0] key_code;
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W:0]   ev_data;
  logic [2:0]        fifo_count;
  logic              overflow;
  logic              ovf_clear;

  key_event_fifo #(.CODE_W(CODE_W), .DEPTH(DEPTH), .LONG_PRESS_TIME(LPT)) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed), .key_code(key_code),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  // Reference model: event queue plus press bookkeeping.
  logic [CODE_W:0]   mq[$];
  bit                m_ovf, m_block, m_in_press, m_long_sent;
  int                m_hold;
  logic [CODE_W-1:0] m_code;

  // Observation logs taken from the DUT pins.
  logic [CODE_W:0] pops[$];
  int pushc[$];
  int cyc = 0, vcyc = 0;
  logic [2:0] prev_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [CODE_W:0] pop_at(input int i);
    if (i < pops.size()) return pops[i];
    return 'x;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_block = 1; m_in_press = 0; m_long_sent = 0; m_hold = 0; m_code = '0;
  endtask

  // Effect of one clock edge given the inputs currently applied.
  task automatic model_edge();
    bit pop, push, drop;
    logic [CODE_W:0] pd;
    pop = (mq.size() != 0) && ev_ready;
    push = 0; drop = 0; pd = '0;
    if (m_block) begin
      if (!key_pressed) m_block = 0;
    end else if (key_pressed && !m_in_press) begin
      m_in_press = 1; m_hold = 0; m_code = key_code; m_long_sent = 0;
      push = 1; pd = {1'b0, key_code};
    end else if (key_pressed) begin
      m_hold++;
      if (m_hold == LPT - 1 && !m_long_sent) begin
        push = 1; pd = {1'b1, m_code}; m_long_sent = 1;
      end
    end else begin
      m_in_press = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(pd);
      else drop = 1;
    end
    if (drop) m_ovf = 1;
    else if (ovf_clear) m_ovf = 0;
  endtask

  task automatic check_outputs();
    chk("mdl_valid", ev_valid, mq.size() != 0);
    chk("mdl_data", ev_data, (mq.size() != 0) ? mq[0] : '0);
    chk("mdl_count", fifo_count, mq.size());
    chk("mdl_ovf", overflow, m_ovf);
  endtask

  task automatic tick();
    if (ev_valid && ev_ready) pops.push_back(ev_data);
    if (!rst) model_edge();
    @(posedge clk);
    #1;
    cyc++;
    if (ev_valid) vcyc++;
    if (fifo_count > prev_cnt) pushc.push_back(cyc);
    prev_cnt = fifo_count;
    check_outputs();
  endtask

  task automatic clear_logs();
    pops.delete(); pushc.delete(); vcyc = 0; prev_cnt = fifo_count;
  endtask

  task automatic press(input logic [CODE_W-1:0] c);
    key_pressed = 1'b1; key_code = c; tick();
    key_pressed = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; key_pressed = 1'b0; key_code = '0; ev_ready = 1'b0; ovf_clear = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_data", ev_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // 1: short press with consumer ready
    clear_logs();
    ev_ready = 1'b1; key_pressed = 1'b1; key_code = 4'h5;
    repeat (3) tick();
    key_pressed = 1'b0;
    repeat (3) tick();
    chk("t1_npops", pops.size(), 1);
    chk("t1_data", pop_at(0), 5'h05);
    chk("t1_vcyc", vcyc, 1);
    chk("t1_count", fifo_count, 0);

    // 2: long press with consumer stalled
    ev_ready = 1'b0;
    clear_logs();
    key_pressed = 1'b1; key_code = 4'hA;
    repeat (20) tick();
    chk("t2_npush", pushc.size(), 2);
    chk("t2_gap", (pushc.size() >= 2) ? pushc[1] - pushc[0] : -1, 7);
    chk("t2_count", fifo_count, 2);
    key_pressed = 1'b0; tick();
    ev_ready = 1'b1; tick(); tick();
    ev_ready = 1'b0; repeat (3) tick();
    chk("t2_npops", pops.size(), 2);
    chk("t2_pop0", pop_at(0), 5'h0A);
    chk("t2_pop1", pop_at(1), 5'h1A);
    chk("t2_empty", fifo_count, 0);

    // 3: overflow
    for (int c = 1; c <= 5; c++) press(c[CODE_W-1:0]);
    chk("t3_count", fifo_count, 4);
    chk("t3_ovf", overflow, 1);
    clear_logs();
    ev_ready = 1'b1; repeat (4) tick();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) chk("t3_drain", pop_at(i), i + 1);
    chk("t3_ovf_sticky", overflow, 1);
    ovf_clear = 1'b1; tick();
    ovf_clear = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // 4: push and pop together on a full FIFO
    for (int c = 1; c <= 4; c++) press(c[CODE_W-1:0]);
    clear_logs();
    key_pressed = 1'b1; key_code = 4'h6; ev_ready = 1'b1; tick();
    key_pressed = 1'b0; ev_ready = 1'b0; tick();
    chk("t4_npops", pops.size(), 1);
    chk("t4_pop0", pop_at(0), 5'h01);
    chk("t4_count", fifo_count, 4);
    chk("t4_ovf", overflow, 0);
    clear_logs();
    ev_ready = 1'b1; repeat (4) tick();
    ev_ready = 1'b0; tick();
    chk("t4_d0", pop_at(0), 5'h02);
    chk("t4_d1", pop_at(1), 5'h03);
    chk("t4_d2", pop_at(2), 5'h04);
    chk("t4_d3", pop_at(3), 5'h06);

    // 5: reset while a key is held
    key_pressed = 1'b1; key_code = 4'h9;
    tick(); tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_async_valid", ev_valid, 0);
    chk("t5_async_count", fifo_count, 0);
    chk("t5_async_data", ev_data, 0);
    tick(); tick();
    rst = 1'b0;
    clear_logs();
    repeat (10) tick();
    chk("t5_hold_vcyc", vcyc, 0);
    key_pressed = 1'b0; tick();
    key_pressed = 1'b1; key_code = 4'h7; tick();
    key_pressed = 1'b0; ev_ready = 1'b1;
    repeat (3) tick();
    ev_ready = 1'b0;
    chk("t5_npops", pops.size(), 1);
    chk("t5_pop0", pop_at(0), 5'h07);

    // 6: backpressure keeps head stable
    press(4'h3);
    press(4'hC);
    clear_logs();
    repeat (5) begin
      tick();
      chk("t6_hold_data", ev_data, 5'h03);
      chk("t6_hold_count", fifo_count, 2);
    end
    ev_ready = 1'b1; tick(); tick();
    ev_ready = 1'b0;
    chk("t6_pop0", pop_at(0), 5'h03);
    chk("t6_pop1", pop_at(1), 5'h0C);
    chk("t6_valid", ev_valid, 0);

    // Random phase against the reference model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) key_pressed = !key_pressed;
      key_code  = CODE_W'($urandom_range(0, 15));
      ev_ready  = ($urandom_range(0, 2) == 0);
      ovf_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the key debouncer in the keypad interface.
- Takes the debounced key level and the scanner's key code, and turns presses into discrete events.
- Each key generates one short-press event and at most one long-press event.
- Events are buffered in a small FIFO and read by the consumer (display/control logic) through a valid/ready handshake.

Parameters:
- CODE_W, 4: width of key code.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- LONG_PRESS_TIME, 1000: cycles of continuous hold, counted from the press edge, before the long event is emitted; ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_pressed  in  1  debounced key level (1 = held), synchronous to clk.
- key_code  in  CODE_W  code of the held key; valid whenever key_pressed=1.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_data  out  CODE_W+1  {long_flag, code} at FIFO head.
- fifo_count  out  $clog2(DEPTH)+1  number of stored events, 0..DEPTH.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- ovf_clear  in  1  single-cycle pulse; clears overflow.

Behaviour:
- Reset values:
  - ev_valid=0, ev_data=0, fifo_count=0, overflow=0.
  - FIFO pointers 0, hold counter 0, FSM in ARM.
- FSM states and transitions:
  - ARM: wait for key_pressed=0, then go to IDLE. No events. A key still held when rst releases produces no event.
  - IDLE: key_pressed=1 → push {0,key_code}, clear counter, latch key_code, go to HELD.
  - HELD: counter increments each cycle while key_pressed=1.
    - Counter reaches LONG_PRESS_TIME-1 → push {1,latched code}, go to LONG_DONE.
    - key_pressed=0 → IDLE.
  - LONG_DONE: key_pressed=0 → IDLE. No further events while held (no auto-repeat).
- Long-event code: uses the code latched at the press edge; key_code changes during hold are ignored.
- Release: any key_pressed low cycle counts as a release; debouncer glitches are not filtered again here.
- Counter width: $clog2(LONG_PRESS_TIME) bits; saturates/never wraps inside HELD.
- FIFO:
  - First-word-fall-through; ev_data is registered from the head entry.
  - Push at edge N into an empty FIFO → ev_valid=1 and ev_data valid after edge N (visible in cycle N+1). One cycle latency from key_pressed sampled high to ev_valid.
  - Pop occurs on an edge where ev_valid=1 and ev_ready=1.
  - ev_ready while ev_valid=0 has no effect. fifo_count never underflows.
  - ev_data is stable while ev_valid=1 and ev_ready=0.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push and pop:
  - FIFO not empty: both occur, count unchanged.
  - FIFO full: pop frees a slot, push is accepted, no overflow.
  - FIFO empty: push only (no valid head to pop). ev_valid=1 after the edge.
- Full FIFO, push without pop: event dropped, overflow set on that edge, FIFO contents unchanged. Drops continue until space frees.
- overflow clearing:
  - ovf_clear clears overflow.
  - ovf_clear on the same edge as a new drop: overflow stays set (set wins).
- rst asserted mid-operation: all state and FIFO contents discarded immediately (async), outputs go to reset values, FSM returns to ARM.

Test Plan (bench uses DEPTH=4, LONG_PRESS_TIME=8, CODE_W=4):
1. Short press: key_pressed high 3 cycles with key_code=4'h5, ev_ready=1.
   - ev_valid pulses 1 cycle, ev_data=5'h05, exactly one event, fifo_count returns to 0.
2. Long press: hold key_code=4'hA for 20 cycles, ev_ready=0.
   - Two events, fifo_count=2.
   - Second pushed 7 cycles after the first.
   - Drain yields 5'h0A then 5'h1A. No third event.
3. Overflow: ev_ready=0, five separate short presses with codes 1,2,3,4,5.
   - fifo_count=4, overflow=1.
   - Drain yields 1,2,3,4.
   - ovf_clear pulse → overflow=0.
4. Full push+pop: FIFO full (1,2,3,4), hold ev_ready=1 on the same edge as a press of code 6.
   - 1 popped, 6 accepted, fifo_count=4, overflow=0.
   - Drain order 2,3,4,6.
5. Reset while held: key_pressed=1, pulse rst for 2 cycles, keep key held 10 more cycles, then release and press code 7.
   - No event during hold, ev_valid=0 throughout.
   - Only event after release is 5'h07.
6. Backpressure stability: 2 events queued, ev_ready=0 for 5 cycles.
   - ev_data constant at first event, fifo_count=2.
   - ev_ready=1 for 2 cycles → both popped in order, ev_valid=0.
